branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter PC_W, default 9, meaning the program-counter width in bits.
REQ-002 SHALL have parameter ENTRIES, default 16, meaning the number of direct-mapped table entries; it SHALL be a power of 2 and at least 2.
REQ-003 SHALL have parameter CNT_W, default 32, meaning the width of the statistics counters.
REQ-004 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-low reset (0 = reset on the next clk edge).
REQ-006 Port if_pc, input, PC_W: fetch-stage PC to look up.
REQ-007 Port pred_hit, output, 1: a valid entry's tag matches if_pc.
REQ-008 Port pred_taken, output, 1: predicted taken. Equals pred_hit AND counter[1].
REQ-009 Port pred_target, output, 32: stored target if pred_taken, otherwise {zero-ext if_pc}+4.
REQ-010 Port ex_valid, input, 1: an instruction is resolved in EX this cycle.
REQ-011 Ports ex_pc (PC_W), ex_is_branch (1), ex_is_jump (1), ex_taken (1), ex_target (32): inputs giving the resolved instruction's PC, its kind, actual outcome and actual target.
REQ-012 Ports ex_pred_taken (1) and ex_pred_target (32): inputs carrying the prediction made at fetch, piped down to EX.
REQ-013 Port mispredict, output, 1: flush request for the younger instructions.
REQ-014 Port redirect_pc, output, 32: the correct next PC, meaningful while mispredict=1.
REQ-015 Ports branch_cnt and mispred_cnt, output, CNT_W: statistics counters.

Function
REQ-016 SHALL use IDX_W=log2(ENTRIES), index = pc[IDX_W+1:2] and tag = pc[PC_W-1:IDX_W+2]; elaboration SHALL fail if PC_W < IDX_W+3.
REQ-017 Each entry SHALL hold: valid, tag, 32-bit target and a 2-bit saturating counter (SNT=00, WNT=01, WT=10, ST=11).
REQ-018 Lookup SHALL be combinational from registered table state, with zero-cycle latency.
REQ-019 A same-cycle update to the looked-up index SHALL NOT be bypassed; lookup returns the pre-edge contents.
REQ-020 ctrl is defined as ex_is_branch OR ex_is_jump; act_taken is defined as ex_is_jump OR (ex_is_branch AND ex_taken).
REQ-021 act_next SHALL be ex_target when act_taken, otherwise {zero-ext ex_pc}+4.
REQ-022 mispredict SHALL be combinational and equal ex_valid AND (ex_pred_taken != act_taken OR (act_taken AND ex_pred_target != ex_target)).
REQ-023 redirect_pc SHALL equal act_next; this also covers a non-control instruction that was predicted taken (alias), which redirects to PC+4.
REQ-024 Update on tag hit with ctrl: the counter SHALL increment if act_taken and decrement otherwise, saturating at ST/SNT with no wrap; target <= ex_target when act_taken.
REQ-025 Update on jump: the counter SHALL be forced to ST.
REQ-026 Update on miss with ctrl and act_taken: the entry SHALL be allocated (overwrite), valid=1, with tag and target written and counter=WT (ST for a jump).
REQ-027 A miss with not-taken SHALL NOT allocate.
REQ-028 Update on hit with ex_valid AND NOT ctrl (alias): the entry SHALL be invalidated.
REQ-029 With ex_valid=0, the table and counters SHALL remain unchanged.
REQ-030 branch_cnt SHALL increment on each ex_valid AND ctrl; mispred_cnt SHALL increment on each mispredict. Both saturate at all-ones and do not wrap.

Reset
REQ-031 On reset=0 at a clk edge, all valid bits, counters (SNT) and branch_cnt/mispred_cnt SHALL clear to 0; tags and targets are don't-care.
REQ-032 During reset, update inputs SHALL be ignored; outputs SHALL follow the cleared state (pred_hit=0, pred_taken=0). mispredict remains combinational from its inputs.
REQ-033 A reset asserted mid-stream SHALL take priority over a simultaneous update.

Structure
REQ-034 Package bp_pkg SHALL hold the counter-state enum, the entry struct typedef and the +4 constant.
REQ-035 Sub-module bp_sat_counter (2-bit next-state logic: inc/dec/force-ST) SHALL be instantiated per update path.
REQ-036 The table SHALL be a flop array of ENTRIES entries with no SRAM macro.

Verification
REQ-037 After reset, if_pc=0x040 -> pred_hit=0, pred_taken=0, pred_target=0x044.
REQ-038 Branch at 0x040 taken to 0x100 with ex_pred_taken=0 -> mispredict=1, redirect_pc=0x100; the next cycle lookup of 0x040 gives pred_taken=1, pred_target=0x100 (WT).
REQ-039 Same branch resolved not-taken twice from WT -> WNT then SNT, pred_taken=0; a third not-taken stays SNT with no wrap.
REQ-040 Two PCs aliasing to the same index (0x040 and 0x080 with ENTRIES=16) -> the second taken branch overwrites the entry; lookup of 0x040 misses.
REQ-041 Non-control instruction at 0x040 with ex_pred_taken=1 -> mispredict=1, redirect_pc=0x044, entry invalidated.
REQ-042 Update and lookup at the same index in the same cycle -> lookup returns old data; reset asserted alongside an update -> table is cleared and the update is dropped.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and constants for the branch predictor.
//   ctr_state_e : 2-bit saturating direction counter states
//   bp_entry_t  : per-entry payload (valid, counter, target); the tag is kept
//                 beside it because its width depends on module parameters
//   PC_INC      : sequential fetch increment
//   seq_next()  : fall-through PC for a 32-bit zero-extended PC
package bp_pkg;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_state_e;

  typedef struct packed {
    logic        valid;
    ctr_state_e  ctr;
    logic [31:0] target;
  } bp_entry_t;

  localparam logic [31:0] PC_INC = 32'd4;

  function automatic logic [31:0] seq_next(input logic [31:0] pc);
    return pc + PC_INC;
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Next-state logic for one 2-bit saturating direction counter.
//   state_cur  : current counter state
//   inc / dec  : move one step towards ST / SNT, saturating at the ends
//   force_st   : jump to ST (highest priority)
//   state_next : resulting state
module bp_sat_counter
  import bp_pkg::*;
(
  input  ctr_state_e state_cur,
  input  logic       inc,
  input  logic       dec,
  input  logic       force_st,
  output ctr_state_e state_next
);

  always_comb begin
    state_next = state_cur;
    if (force_st) begin
      state_next = CTR_ST;
    end else if (inc) begin
      case (state_cur)
        CTR_SNT: state_next = CTR_WNT;
        CTR_WNT: state_next = CTR_WT;
        default: state_next = CTR_ST;
      endcase
    end else if (dec) begin
      case (state_cur)
        CTR_ST:  state_next = CTR_WT;
        CTR_WT:  state_next = CTR_WNT;
        default: state_next = CTR_SNT;
      endcase
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
//   clk, reset (sync, active-low)
//   if_pc -> pred_hit / pred_taken / pred_target   (combinational lookup)
//   ex_*  -> mispredict / redirect_pc               (combinational resolve)
//            plus the table update on the next clk edge
//   branch_cnt / mispred_cnt : saturating statistics counters
module branch_predictor
  import bp_pkg::*;
#(
  parameter int PC_W    = 9,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PC_W-1:0]  if_pc,
  output logic             pred_hit,
  output logic             pred_taken,
  output logic [31:0]      pred_target,
  input  logic             ex_valid,
  input  logic [PC_W-1:0]  ex_pc,
  input  logic             ex_is_branch,
  input  logic             ex_is_jump,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  input  logic             ex_pred_taken,
  input  logic [31:0]      ex_pred_target,
  output logic             mispredict,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;

  generate
    if (ENTRIES < 2 || (ENTRIES & (ENTRIES - 1)) != 0) begin : g_bad_entries
      $error("branch_predictor: ENTRIES must be a power of 2 and at least 2");
    end
    if (PC_W < IDX_W + 3 || PC_W > 32) begin : g_bad_pc_w
      $error("branch_predictor: PC_W must be in [IDX_W+3, 32]");
    end
  endgenerate

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[PC_W-1:IDX_W+2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[PC_W-1:IDX_W+2];

  // Read views of the per-entry registers, indexed by lookup/update ports.
  bp_entry_t        entry_cur [ENTRIES];
  logic [TAG_W-1:0] tag_cur   [ENTRIES];

  // ---------------- Lookup (pre-edge table contents, no bypass) ----------------
  bp_entry_t  if_entry;
  logic [1:0] if_ctr_bits;

  assign if_entry    = entry_cur[if_idx];
  assign if_ctr_bits = if_entry.ctr;
  // Gated with reset so the outputs look like the cleared table while reset is held.
  assign pred_hit    = reset & if_entry.valid & (tag_cur[if_idx] == if_tag);
  assign pred_taken  = pred_hit & if_ctr_bits[1];
  assign pred_target = pred_taken ? if_entry.target : seq_next(32'(if_pc));

  // ---------------- Resolve ----------------
  logic        ctrl, act_taken, ex_hit;
  logic [31:0] act_next;

  assign ctrl        = ex_is_branch | ex_is_jump;
  assign act_taken   = ex_is_jump | (ex_is_branch & ex_taken);
  assign act_next    = act_taken ? ex_target : seq_next(32'(ex_pc));
  assign mispredict  = ex_valid & ((ex_pred_taken != act_taken) |
                                   (act_taken & (ex_pred_target != ex_target)));
  assign redirect_pc = act_next;
  assign ex_hit      = entry_cur[ex_idx].valid & (tag_cur[ex_idx] == ex_tag);

  // ---------------- Table entries ----------------
  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
      bp_entry_t        entry_reg;
      logic [TAG_W-1:0] tag_reg;
      ctr_state_e       ctr_next;
      logic             upd;

      assign upd           = ex_valid & (ex_idx == IDX_W'(gi));
      assign entry_cur[gi] = entry_reg;
      assign tag_cur[gi]   = tag_reg;

      bp_sat_counter u_ctr (
        .state_cur  (entry_reg.ctr),
        .inc        (act_taken),
        .dec        (~act_taken),
        .force_st   (ex_is_jump),
        .state_next (ctr_next)
      );

      always_ff @(posedge clk) begin
        if (!reset) begin
          entry_reg.valid <= 1'b0;
          entry_reg.ctr   <= CTR_SNT;
        end else if (upd) begin
          if (ex_hit) begin
            if (ctrl) begin
              entry_reg.ctr <= ctr_next;
              if (act_taken) entry_reg.target <= ex_target;
            end else begin
              // Non-control instruction matched: the entry is a stale alias.
              entry_reg.valid <= 1'b0;
            end
          end else if (ctrl && act_taken) begin
            entry_reg.valid  <= 1'b1;
            entry_reg.ctr    <= ex_is_jump ? CTR_ST : CTR_WT;
            entry_reg.target <= ex_target;
            tag_reg          <= ex_tag;
          end
        end
      end
    end
  endgenerate

  // ---------------- Statistics ----------------
  logic [CNT_W-1:0] branch_cnt_reg, mispred_cnt_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      branch_cnt_reg  <= '0;
      mispred_cnt_reg <= '0;
    end else begin
      if (ex_valid && ctrl && branch_cnt_reg != '1)
        branch_cnt_reg <= branch_cnt_reg + CNT_W'(1);
      if (mispredict && mispred_cnt_reg != '1)
        mispred_cnt_reg <= mispred_cnt_reg + CNT_W'(1);
    end
  end

  assign branch_cnt  = branch_cnt_reg;
  assign mispred_cnt = mispred_cnt_reg;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus a
// randomized run checked against a behavioural table model.
module tb_branch_predictor;

  localparam int PC_W    = 9;
  localparam int ENTRIES = 16;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [PC_W-1:0]  if_pc;
  logic             pred_hit, pred_taken;
  logic [31:0]      pred_target;
  logic             ex_valid;
  logic [PC_W-1:0]  ex_pc;
  logic             ex_is_branch, ex_is_jump, ex_taken;
  logic [31:0]      ex_target;
  logic             ex_pred_taken;
  logic [31:0]      ex_pred_target;
  logic             mispredict;
  logic [31:0]      redirect_pc;
  logic [CNT_W-1:0] branch_cnt, mispred_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  branch_predictor #(.PC_W(PC_W), .ENTRIES(ENTRIES), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .if_pc(if_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_is_branch(ex_is_branch),
    .ex_is_jump(ex_is_jump), .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  // ---------------- Behavioural model ----------------
  bit          m_valid  [ENTRIES];
  int          m_tag    [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  int          m_ctr    [ENTRIES];
  int          m_bcnt, m_mcnt;

  function automatic void m_clear();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0;
      m_ctr[i]   = 0;
    end
    m_bcnt = 0;
    m_mcnt = 0;
  endfunction

  function automatic void m_lookup(input int pc, output bit hit, output bit tk,
                                   output logic [31:0] tgt);
    int idx, tg;
    idx = (pc / 4) % ENTRIES;
    tg  = pc / (4 * ENTRIES);
    hit = m_valid[idx] && (m_tag[idx] == tg);
    tk  = hit && (m_ctr[idx] >= 2);
    tgt = tk ? m_target[idx] : 32'(pc + 4);
  endfunction

  function automatic void m_resolve(input int pc, input bit br, input bit j, input bit tk,
                                    input logic [31:0] tgt, input bit ptk,
                                    input logic [31:0] ptgt,
                                    output bit mis, output logic [31:0] nxt);
    bit act;
    act = j || (br && tk);
    nxt = act ? tgt : 32'(pc + 4);
    mis = (ptk != act) || (act && ptgt != tgt);
  endfunction

  function automatic void m_update(input int pc, input bit br, input bit j, input bit tk,
                                   input logic [31:0] tgt, input bit mis);
    int idx, tg;
    bit act, ctrl, hit;
    idx  = (pc / 4) % ENTRIES;
    tg   = pc / (4 * ENTRIES);
    ctrl = br || j;
    act  = j || (br && tk);
    hit  = m_valid[idx] && (m_tag[idx] == tg);
    if (ctrl && m_bcnt < CNT_MAX) m_bcnt++;
    if (mis && m_mcnt < CNT_MAX) m_mcnt++;
    if (hit) begin
      if (ctrl) begin
        if (j) m_ctr[idx] = 3;
        else if (act) m_ctr[idx] = (m_ctr[idx] == 3) ? 3 : m_ctr[idx] + 1;
        else m_ctr[idx] = (m_ctr[idx] == 0) ? 0 : m_ctr[idx] - 1;
        if (act) m_target[idx] = tgt;
      end else begin
        m_valid[idx] = 0;
      end
    end else if (ctrl && act) begin
      m_valid[idx]  = 1;
      m_tag[idx]    = tg;
      m_target[idx] = tgt;
      m_ctr[idx]    = j ? 3 : 2;
    end
  endfunction

  // ---------------- Stimulus helpers (no checking) ----------------
  task automatic drive(input logic [PC_W-1:0] f_pc, input logic v, input logic [PC_W-1:0] e_pc,
                       input logic br, input logic j, input logic tk, input logic [31:0] tgt,
                       input logic ptk, input logic [31:0] ptgt);
    @(negedge clk);
    if_pc = f_pc; ex_valid = v; ex_pc = e_pc; ex_is_branch = br; ex_is_jump = j;
    ex_taken = tk; ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
    #1;
    $display("[TB] t=%0t rst=%b if=%h | ex v=%b pc=%h br=%b j=%b tk=%b tgt=%h ptk=%b ptgt=%h | hit=%b ptaken=%b ptgt=%h mis=%b redir=%h",
             $time, reset, f_pc, v, e_pc, br, j, tk, tgt, ptk, ptgt,
             pred_hit, pred_taken, pred_target, mispredict, redirect_pc);
  endtask

  task automatic look(input logic [PC_W-1:0] f_pc);
    drive(f_pc, 1'b0, '0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    look(9'h000);
    tick();
    reset = 1'b1;
  endtask

  // ---------------- Directed tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    // Update offered during reset; mispredict remains combinational.
    drive(9'h040, 1'b1, 9'h040, 1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 32'h044);
    n_tests++; if (mispredict !== 1'b1) begin n_fail++; $display("FAIL rst_mispredict_comb got=%b exp=1", mispredict); end
    tick();
    look(9'h040);
    tick();
    n_tests++; if (pred_hit !== 1'b0) begin n_fail++; $display("FAIL rst_hold_hit got=%b exp=0", pred_hit); end
    reset = 1'b1;
    look(9'h040);
    n_tests++; if (pred_hit !== 1'b0) begin n_fail++; $display("FAIL rst_hit got=%b exp=0", pred_hit); end
    n_tests++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL rst_taken got=%b exp=0", pred_taken); end
    n_tests++; if (pred_target !== 32'h044) begin n_fail++; $display("FAIL rst_target got=%h exp=00000044", pred_target); end
    n_tests++; if (branch_cnt !== '0) begin n_fail++; $display("FAIL rst_branch_cnt got=%0d exp=0", branch_cnt); end
    n_tests++; if (mispred_cnt !== '0) begin n_fail++; $display("FAIL rst_mispred_cnt got=%0d exp=0", mispred_cnt); end
  endtask

  task automatic test_taken_and_saturation();
    do_reset();
    drive(9'h040, 1'b1, 9'h040, 1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 32'h044);
    n_tests++; if (mispredict !== 1'b1) begin n_fail++; $display("FAIL alloc_mispredict got=%b exp=1", mispredict); end
    n_tests++; if (redirect_pc !== 32'h100) begin n_fail++; $display("FAIL alloc_redirect got=%h exp=00000100", redirect_pc); end
    tick();
    look(9'h040);
    n_tests++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL alloc_taken got=%b exp=1", pred_taken); end
    n_tests++; if (pred_target !== 32'h100) begin n_fail++; $display("FAIL alloc_target got=%h exp=00000100", pred_target); end
    // WT -> WNT: predicted taken but resolved not taken.
    drive(9'h040, 1'b1, 9'h040, 1'b1, 1'b0, 1'b0, 32'h100, 1'b1, 32'h100);
    n_tests++; if (redirect_pc !== 32'h044) begin n_fail++; $display("FAIL nt_redirect got=%h exp=00000044", redirect_pc); end
    tick();
    look(9'h040);
    n_tests++; if (pred_hit !== 1'b1 || pred_taken !== 1'b0) begin n_fail++; $display("FAIL wnt_pred got=hit%b/tk%b exp=hit1/tk0", pred_hit, pred_taken); end
    // WNT -> SNT, then SNT stays SNT.
    drive(9'h040, 1'b1, 9'h040, 1'b1, 1'b0, 1'b0, 32'h100, 1'b0, 32'h044);
    n_tests++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL nt_correct_mispredict got=%b exp=0", mispredict); end
    tick();
    drive(9'h040, 1'b1, 9'h040, 1'b1, 1'b0, 1'b0, 32'h100, 1'b0, 32'h044);
    tick();
    // One taken from SNT must give WNT (a wrapped counter would give taken).
    drive(9'h040, 1'b1, 9'h040, 1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 32'h044);
    tick();
    look(9'h040);
    n_tests++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL snt_no_wrap got=%b exp=0", pred_taken); end
    drive(9'h040, 1'b1, 9'h040, 1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 32'h044);
    tick();
    look(9'h040);
    n_tests++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL wnt_to_wt got=%b exp=1", pred_taken); end
  endtask

  task automatic test_alias_and_invalidate();
    do_reset();
    drive(9'h000, 1'b1, 9'h040, 1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0);
    tick();
    drive(9'h000, 1'b1, 9'h080, 1'b1, 1'b0, 1'b1, 32'h200, 1'b0, 32'h0);
    tick();
    look(9'h040);
    n_tests++; if (pred_hit !== 1'b0) begin n_fail++; $display("FAIL alias_old_hit got=%b exp=0", pred_hit); end
    look(9'h080);
    n_tests++; if (pred_target !== 32'h200) begin n_fail++; $display("FAIL alias_new_target got=%h exp=00000200", pred_target); end
    // Non-control at 0x080 that was predicted taken: redirect to PC+4, invalidate.
    drive(9'h000, 1'b1, 9'h080, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h200);
    n_tests++; if (mispredict !== 1'b1) begin n_fail++; $display("FAIL nonctl_mispredict got=%b exp=1", mispredict); end
    n_tests++; if (redirect_pc !== 32'h084) begin n_fail++; $display("FAIL nonctl_redirect got=%h exp=00000084", redirect_pc); end
    tick();
    look(9'h080);
    n_tests++; if (pred_hit !== 1'b0) begin n_fail++; $display("FAIL nonctl_invalidate got=%b exp=0", pred_hit); end
    // Jump allocates at ST: one not-taken branch still leaves it predicted taken.
    drive(9'h000, 1'b1, 9'h0c0, 1'b0, 1'b1, 1'b0, 32'h1f0, 1'b0, 32'h0);
    tick();
    drive(9'h000, 1'b1, 9'h0c0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1f0);
    tick();
    look(9'h0c0);
    n_tests++; if (pred_taken !== 1'b1 || pred_target !== 32'h1f0) begin n_fail++; $display("FAIL jump_st got=tk%b/%h exp=tk1/000001f0", pred_taken, pred_target); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    drive(9'h000, 1'b1, 9'h040, 1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0);
    tick();
    drive(9'h040, 1'b1, 9'h040, 1'b1, 1'b0, 1'b1, 32'h300, 1'b1, 32'h100);
    n_tests++; if (pred_target !== 32'h100) begin n_fail++; $display("FAIL same_cycle_old got=%h exp=00000100", pred_target); end
    n_tests++; if (mispredict !== 1'b1 || redirect_pc !== 32'h300) begin n_fail++; $display("FAIL target_mispredict got=%b/%h exp=1/00000300", mispredict, redirect_pc); end
    tick();
    look(9'h040);
    n_tests++; if (pred_target !== 32'h300) begin n_fail++; $display("FAIL same_cycle_new got=%h exp=00000300", pred_target); end
    // Reset alongside an update: the update is dropped and the table cleared.
    reset = 1'b0;
    drive(9'h040, 1'b1, 9'h0c0, 1'b1, 1'b0, 1'b1, 32'h150, 1'b0, 32'h0);
    tick();
    reset = 1'b1;
    look(9'h0c0);
    n_tests++; if (pred_hit !== 1'b0) begin n_fail++; $display("FAIL rst_prio_update got=%b exp=0", pred_hit); end
    look(9'h040);
    n_tests++; if (pred_hit !== 1'b0) begin n_fail++; $display("FAIL rst_prio_clear got=%b exp=0", pred_hit); end
    n_tests++; if (branch_cnt !== '0 || mispred_cnt !== '0) begin n_fail++; $display("FAIL rst_prio_cnt got=%0d/%0d exp=0/0", branch_cnt, mispred_cnt); end
  endtask

  task automatic test_cnt_saturation();
    do_reset();
    for (int i = 1; i <= CNT_MAX + 5; i++) begin
      drive(9'h000, 1'b1, 9'h100, 1'b1, 1'b0, 1'b1, 32'h180, 1'b0, 32'h0);
      tick();
      if (i == 3) begin
        n_tests++; if (branch_cnt !== 4'd3 || mispred_cnt !== 4'd3) begin n_fail++; $display("FAIL cnt_step got=%0d/%0d exp=3/3", branch_cnt, mispred_cnt); end
      end
    end
    n_tests++; if (branch_cnt !== 4'hf) begin n_fail++; $display("FAIL branch_cnt_sat got=%0d exp=15", branch_cnt); end
    n_tests++; if (mispred_cnt !== 4'hf) begin n_fail++; $display("FAIL mispred_cnt_sat got=%0d exp=15", mispred_cnt); end
  endtask

  // ---------------- Randomized test ----------------
  task automatic test_random();
    logic [31:0] tgts [4];
    tgts[0] = 32'h100; tgts[1] = 32'h104; tgts[2] = 32'h3f0; tgts[3] = 32'habc0;
    do_reset();
    m_clear();
    for (int n = 0; n < 300; n++) begin
      logic [PC_W-1:0] f_pc, e_pc;
      bit v, br, j, tk, ptk, mis, e_hit, e_tk, f_hit, f_tk;
      logic [31:0] tgt, ptgt, e_tgt, f_tgt, nxt;
      int kind;
      f_pc = PC_W'($urandom_range(0, 7) * 64 + $urandom_range(0, 3) * 4 + $urandom_range(0, 3));
      e_pc = PC_W'($urandom_range(0, 7) * 64 + $urandom_range(0, 3) * 4 + $urandom_range(0, 3));
      v    = ($urandom_range(0, 9) != 0);
      kind = $urandom_range(0, 9);
      br   = (kind <= 5);
      j    = (kind == 6 || kind == 7);
      tk   = $urandom_range(0, 1) != 0;
      tgt  = tgts[$urandom_range(0, 3)];
      m_lookup(int'(e_pc), e_hit, e_tk, e_tgt);
      if ($urandom_range(0, 9) < 7) begin
        ptk = e_tk; ptgt = e_tgt;
      end else begin
        ptk = $urandom_range(0, 1) != 0; ptgt = tgts[$urandom_range(0, 3)];
      end
      reset = ($urandom_range(0, 39) != 0);
      m_lookup(int'(f_pc), f_hit, f_tk, f_tgt);
      m_resolve(int'(e_pc), br, j, tk, tgt, ptk, ptgt, mis, nxt);
      drive(f_pc, v, e_pc, br, j, tk, tgt, ptk, ptgt);
      n_tests++; if (mispredict !== (v && mis)) begin n_fail++; $display("FAIL rnd_mispredict n=%0d got=%b exp=%b", n, mispredict, v && mis); end
      n_tests++; if (redirect_pc !== nxt) begin n_fail++; $display("FAIL rnd_redirect n=%0d got=%h exp=%h", n, redirect_pc, nxt); end
      if (reset) begin
        n_tests++; if (pred_hit !== f_hit) begin n_fail++; $display("FAIL rnd_hit n=%0d got=%b exp=%b", n, pred_hit, f_hit); end
        n_tests++; if (pred_taken !== f_tk) begin n_fail++; $display("FAIL rnd_taken n=%0d got=%b exp=%b", n, pred_taken, f_tk); end
        n_tests++; if (pred_target !== f_tgt) begin n_fail++; $display("FAIL rnd_target n=%0d got=%h exp=%h", n, pred_target, f_tgt); end
      end
      tick();
      if (!reset) m_clear();
      else if (v) m_update(int'(e_pc), br, j, tk, tgt, mis);
      n_tests++; if (branch_cnt !== CNT_W'(m_bcnt)) begin n_fail++; $display("FAIL rnd_branch_cnt n=%0d got=%0d exp=%0d", n, branch_cnt, m_bcnt); end
      n_tests++; if (mispred_cnt !== CNT_W'(m_mcnt)) begin n_fail++; $display("FAIL rnd_mispred_cnt n=%0d got=%0d exp=%0d", n, mispred_cnt, m_mcnt); end
      // Periodic resets keep the saturating counters from pinning at max.
      if (n % 40 == 39) begin
        do_reset();
        m_clear();
      end
    end
  endtask

  initial begin
    reset = 1'b0; if_pc = '0; ex_valid = 1'b0; ex_pc = '0; ex_is_branch = 1'b0;
    ex_is_jump = 1'b0; ex_taken = 1'b0; ex_target = '0; ex_pred_taken = 1'b0;
    ex_pred_target = '0;
    test_reset();
    test_taken_and_saturation();
    test_alias_and_invalidate();
    test_same_cycle();
    test_cnt_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
